// File: rtl/key_mode_sel.sv
// Debounced multi-key selector: per-key synchronizer + press FSM feeding a one-hot mode register.
// Optional auto-repeat is compiled in when KEY_REPEAT_EN is defined.
module key_mode_sel #(
    parameter  int unsigned NUM_KEYS    = 4,
    parameter  int unsigned CNT_MAX     = 999_999,
    parameter  int unsigned DEFAULT_SEL = 0,
    parameter  int unsigned LONG_CNT    = 49_999_999,
    parameter  int unsigned REPEAT_CNT  = 9_999_999,
    localparam int unsigned IDX_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] sel_onehot,
    output logic [IDX_W-1:0]    sel_idx,
    output logic                sel_chg
);

`ifdef KEY_REPEAT_EN
    localparam int unsigned CNT_HI12 = (CNT_MAX > LONG_CNT) ? CNT_MAX : LONG_CNT;
    localparam int unsigned CNT_TOP  = (CNT_HI12 > REPEAT_CNT) ? CNT_HI12 : REPEAT_CNT;
`else
    localparam int unsigned CNT_TOP  = CNT_MAX;
`endif
    localparam int unsigned CNT_W = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

    if (NUM_KEYS == 0 || NUM_KEYS > 16 || CNT_MAX < 2 || CNT_MAX > 32'd16_777_215 ||
        DEFAULT_SEL >= NUM_KEYS || LONG_CNT == 0 || REPEAT_CNT == 0) begin : g_bad_param
        $error("key_mode_sel: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
`ifdef KEY_REPEAT_EN
        ,
        REPEAT   = 2'd3
`endif
    } state_t;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    state_t              state_q [NUM_KEYS];
    state_t              state_d [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] pulse_q, pulse_d;

    logic [NUM_KEYS-1:0] sel_oh_q, sel_oh_d;
    logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
    logic                sel_chg_q, sel_chg_d;
    logic                hit_c;
    logic [IDX_W-1:0]    pick_c;

    // Two-flop synchronizers; idle level of an active-low key is 1.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pulse_q <= pulse_d;
        end
    end

    // Per-channel press FSM; release is taken immediately, press must hold for CNT_MAX cycles.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (!sync2_q[i]) state_d[i] = DEBOUNCE;
                end
                DEBOUNCE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(CNT_MAX - 1)) begin
                        pulse_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                        state_d[i] = HELD;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (cnt_q[i] == CNT_W'(LONG_CNT - 1)) begin
                        pulse_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                        state_d[i] = REPEAT;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
`endif
                end
`ifdef KEY_REPEAT_EN
                REPEAT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(REPEAT_CNT - 1)) begin
                        pulse_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
`endif
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Lowest-index pulsing channel wins the selection.
    always_comb begin
        hit_c  = 1'b0;
        pick_c = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pulse_q[i] && !hit_c) begin
                hit_c  = 1'b1;
                pick_c = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_oh_d  = sel_oh_q;
        sel_idx_d = sel_idx_q;
        sel_chg_d = 1'b0;
        if (hit_c) begin
            sel_oh_d  = NUM_KEYS'(1) << pick_c;
            sel_idx_d = pick_c;
            sel_chg_d = (pick_c != sel_idx_q);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sel_oh_q  <= NUM_KEYS'(1) << DEFAULT_SEL;
            sel_idx_q <= IDX_W'(DEFAULT_SEL);
            sel_chg_q <= 1'b0;
        end else begin
            sel_oh_q  <= sel_oh_d;
            sel_idx_q <= sel_idx_d;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign press_pulse = pulse_q;
    assign sel_onehot  = sel_oh_q;
    assign sel_idx     = sel_idx_q;
    assign sel_chg     = sel_chg_q;

endmodule

// File: tb/tb_key_mode_sel.sv
// Directed bench for key_mode_sel: expected pulse events are queued at stimulus time and
// checked every cycle together with a selection model.
module tb_key_mode_sel;
    localparam int unsigned NK = 4;
    localparam int unsigned IW = 2;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [NK-1:0] key_in  = '1;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] sel_onehot;
    logic [IW-1:0] sel_idx;
    logic          sel_chg;

    key_mode_sel #(
        .NUM_KEYS   (NK),
        .CNT_MAX    (4),
        .DEFAULT_SEL(0),
        .LONG_CNT   (8),
        .REPEAT_CNT (3)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .press_pulse(press_pulse),
        .sel_onehot (sel_onehot),
        .sel_idx    (sel_idx),
        .sel_chg    (sel_chg)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int unsigned   at;
        logic [NK-1:0] v;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   edge_n = 0;
    logic          rst_at_edge = 1'b1;
    bit            mon_en = 1'b0;
    int            checks = 0;
    int            errors = 0;
    logic [NK-1:0] m_sel = NK'(1);
    logic [NK-1:0] m_prev = '0;
    logic [NK-1:0] m_pulse = '0;
    logic [NK-1:0] m_nxt;
    logic          m_chg = 1'b0;

    always @(posedge sys_clk) begin
        edge_n      <= edge_n + 1;
        rst_at_edge <= sys_rst;
    end

    function automatic logic [NK-1:0] lowest(input logic [NK-1:0] v);
        logic [NK-1:0] r;
        r = '0;
        for (int i = NK - 1; i >= 0; i--) if (v[i]) r = NK'(1) << i;
        return r;
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [NK-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NK; i++) if (oh[i]) r = IW'(i);
        return r;
    endfunction

    task automatic push_exp(input int unsigned at, input logic [NK-1:0] v);
        exp_t e;
        e.at = at;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    // Cycle monitor: outputs after edge N are compared with the queued events and selection model.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (rst_at_edge) begin
                m_sel   = NK'(1);
                m_chg   = 1'b0;
                m_pulse = '0;
            end else begin
                if (m_prev != '0) begin
                    m_nxt = lowest(m_prev);
                    m_chg = (m_nxt != m_sel);
                    m_sel = m_nxt;
                end else begin
                    m_chg = 1'b0;
                end
                m_pulse = '0;
                if (exp_q.size() > 0) begin
                    checks++;
                    assert (exp_q[0].at >= edge_n) else begin
                        errors++;
                        $error("FAIL pulse_missed edge=%0d expected_at=%0d", edge_n, exp_q[0].at);
                        void'(exp_q.pop_front());
                    end
                end
                if (exp_q.size() > 0 && exp_q[0].at == edge_n) begin
                    m_pulse = exp_q[0].v;
                    void'(exp_q.pop_front());
                end
            end
            m_prev = m_pulse;

            checks++;
            assert (press_pulse === m_pulse) else begin
                errors++;
                $error("FAIL press_pulse edge=%0d observed=%b expected=%b", edge_n, press_pulse, m_pulse);
            end
            checks++;
            assert (sel_onehot === m_sel) else begin
                errors++;
                $error("FAIL sel_onehot edge=%0d observed=%b expected=%b", edge_n, sel_onehot, m_sel);
            end
            checks++;
            assert (sel_idx === idx_of(m_sel)) else begin
                errors++;
                $error("FAIL sel_idx edge=%0d observed=%0d expected=%0d", edge_n, sel_idx, idx_of(m_sel));
            end
            checks++;
            assert (sel_chg === m_chg) else begin
                errors++;
                $error("FAIL sel_chg edge=%0d observed=%b expected=%b", edge_n, sel_chg, m_chg);
            end
        end
    end

    initial begin
        int unsigned e0;

        // Reset hold
        sys_rst = 1'b1;
        key_in  = '1;
        repeat (3) @(negedge sys_clk);
        mon_en = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);

        // Single press of key 2, low for 10 samples
        key_in = 4'b1011;
        e0 = edge_n + 1;
        push_exp(e0 + 6, 4'b0100);
        repeat (10) @(negedge sys_clk);
        key_in = '1;
        repeat (10) @(negedge sys_clk);

        // Bouncing key 1 never settles long enough
        for (int r = 0; r < 5; r++) begin
            key_in = 4'b1101;
            repeat (3) @(negedge sys_clk);
            key_in = '1;
            repeat (1) @(negedge sys_clk);
        end
        repeat (8) @(negedge sys_clk);

        // Long hold of key 0
        key_in = 4'b1110;
        e0 = edge_n + 1;
        push_exp(e0 + 6, 4'b0001);
`ifdef KEY_REPEAT_EN
        push_exp(e0 + 14, 4'b0001);
        push_exp(e0 + 17, 4'b0001);
        push_exp(e0 + 20, 4'b0001);
        push_exp(e0 + 23, 4'b0001);
        push_exp(e0 + 26, 4'b0001);
        push_exp(e0 + 29, 4'b0001);
`endif
        repeat (30) @(negedge sys_clk);
        key_in = '1;
        repeat (10) @(negedge sys_clk);

        // Keys 3 and 1 together; lowest index takes the selection
        key_in = 4'b0101;
        e0 = edge_n + 1;
        push_exp(e0 + 6, 4'b1010);
        repeat (8) @(negedge sys_clk);
        key_in = '1;
        repeat (10) @(negedge sys_clk);

        // Reset mid-debounce on key 2, key kept low through and after reset
        key_in = 4'b1011;
        e0 = edge_n + 1;
        repeat (4) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (1) @(negedge sys_clk);
        sys_rst = 1'b0;
        push_exp(e0 + 11, 4'b0100);
        repeat (15) @(negedge sys_clk);
        key_in = '1;
        repeat (10) @(negedge sys_clk);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL pending_pulses observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_mode_sel.md
KEY_MODE_SEL -- requirements
Module: key_mode_sel

Interface
REQ-001 Parameter NUM_KEYS, default 4, number of key channels; legal range 1..16.
REQ-002 Parameter CNT_MAX, default 999_999, debounce hold count in cycles (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-003 Parameter DEFAULT_SEL, default 0, index of the channel selected after reset; legal range 0..NUM_KEYS-1.
REQ-004 Parameter LONG_CNT, default 49_999_999, cycles a key is held past the press pulse before auto-repeat starts; must be at least 1.
REQ-005 Parameter REPEAT_CNT, default 9_999_999, cycles between auto-repeat pulses; must be at least 1.
REQ-006 sys_clk  input  1  single clock for all logic.
REQ-007 sys_rst  input  1  reset; synchronous and active-high.
REQ-008 key_in  input  NUM_KEYS  raw asynchronous keys, active-low (0 = pressed).
REQ-009 press_pulse  output  NUM_KEYS  one-cycle per-channel debounced press (and repeat) strobe.
REQ-010 sel_onehot  output  NUM_KEYS  registered one-hot selection.
REQ-011 sel_idx  output  IDX_W  binary index of the selected channel, where IDX_W = max(1, clog2(NUM_KEYS)).
REQ-012 sel_chg  output  1  one-cycle strobe when the selection changes value.

Function
REQ-013 Each key_in bit SHALL pass through its own 2-flop synchronizer before any other use.
REQ-014 Each channel SHALL run an independent FSM with states IDLE, DEBOUNCE, HELD and REPEAT, plus one counter sized for max(CNT_MAX, LONG_CNT, REPEAT_CNT).
- IDLE: counter is 0; a synced 0 moves the FSM to DEBOUNCE.
- DEBOUNCE: counter increments each cycle while synced is 0; any synced 1 returns the FSM to IDLE with the counter cleared.
REQ-015 When the DEBOUNCE counter reaches CNT_MAX-1, the FSM SHALL pulse press_pulse[i] for one cycle, clear the counter and enter HELD.
- Total latency: press_pulse[i] asserts exactly CNT_MAX+2 cycles after key_in[i] is first sampled 0, provided the key stays low throughout.
REQ-016 HELD and REPEAT SHALL return to IDLE within one cycle of synced 1, clear the counter, and emit no pulse. Release is not debounced.
REQ-017 Auto-repeat (KEY_REPEAT_EN only):
- HELD counts to LONG_CNT-1, then pulses and enters REPEAT.
- REPEAT pulses every REPEAT_CNT cycles while the key is held.
REQ-018 A press pulse on any channel SHALL load the selection on the next clock edge.
- When several bits of press_pulse are high in the same cycle, the lowest-index bit wins.
REQ-019 sel_onehot and sel_idx SHALL always be consistent and update on the same edge; exactly one bit of sel_onehot is high at all times.
REQ-020 sel_chg SHALL be high for exactly the one cycle in which sel_onehot takes a new value different from the old one.
- A repeated press of the already-selected key produces no sel_chg.
REQ-021 Keys that are not pressed SHALL have no effect on any other channel's FSM or counter.

Reset
REQ-022 While sys_rst is high, the block SHALL hold the following values:
- All FSMs in IDLE with counters at 0.
- Synchronizers at 1.
- press_pulse = 0 and sel_chg = 0.
- sel_onehot = 1 << DEFAULT_SEL and sel_idx = DEFAULT_SEL.
REQ-023 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse.
- A key still held when reset is released SHALL be fully re-debounced: press_pulse follows CNT_MAX+2 cycles later.

Configuration
REQ-024 Macro KEY_REPEAT_EN SHALL control auto-repeat.
- Defined: the REPEAT state and the REQ-017 behaviour are compiled in.
- Undefined: HELD waits only for release, exactly one press_pulse occurs per press, the REPEAT state is absent, and the counter is sized for CNT_MAX only.
- The port list is identical in both builds.

Verification
REQ-025 The bench SHALL run with NUM_KEYS=4, CNT_MAX=4, LONG_CNT=8, REPEAT_CNT=3, DEFAULT_SEL=0 and cover these scenarios:
- Reset -> sel_onehot=4'b0001, sel_idx=0, press_pulse=0, sel_chg=0.
- key_in[2] low for 10 cycles, then high -> press_pulse[2] high exactly 6 cycles after the first low sample; next cycle sel_onehot=4'b0100, sel_idx=2, sel_chg=1 for one cycle.
- key_in[1] bounces low 3 cycles / high 1 cycle, repeated 5 times -> no press_pulse and no selection change.
- key_in[3] and key_in[1] low in the same cycle, held for 8 cycles -> both press_pulse bits assert in the same cycle; selection becomes 4'b0010.
- KEY_REPEAT_EN defined, key_in[0] held for 30 cycles -> first pulse at cycle 6, then pulses at 14, 17, 20, 23, 26, 29; no sel_chg after the first. Undefined -> only the pulse at cycle 6.
- sys_rst pulsed at cycle 4 of a key_in[2] press with the key held afterwards -> no pulse before reset; press_pulse[2] 6 cycles after reset release; sel returns to 4'b0001 during reset.
